// File: rtl/edge_detect_top.sv
// Streaming 3x3 Sobel edge detector: RGB -> luminance -> two-line buffer -> window -> magnitude.
// Sync/DE are carried through a matched delay so pixel (x, y) leaves with its own output timing.
module edge_detect_top #(
    parameter int H_ACT   = 640,
    parameter int V_ACT   = 480,
    parameter int H_TOTAL = 800
) (
    input  logic        I_PCLK,
    input  logic        I_RST,
    input  logic [23:0] I_PIX_DATA,
    input  logic        I_VSYNC,
    input  logic        I_HSYNC,
    input  logic        I_DE,
    output logic [23:0] O_PIX_DATA,
    output logic        O_VSYNC,
    output logic        O_HSYNC,
    output logic        O_DE,
    output logic        O_PCLK
);
    localparam int AW = $clog2(H_ACT);
    localparam int RW = $clog2(V_ACT) + 1;
    localparam int PW = $clog2(H_TOTAL);
    localparam logic [AW-1:0] COL_LAST = AW'(H_ACT - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_ACT - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(H_TOTAL - 1);

    assign O_PCLK = I_PCLK;

    // ---------------- stage 1: input register ----------------
    logic [AW-1:0] col_in_reg;
    logic [AW-1:0] col_s1_reg;
    logic [23:0]   pix_s1_reg;
    logic          de_s1_reg;
    logic [2:0]    sync_s1_reg;

    always_ff @(posedge I_PCLK or negedge I_RST) begin
        if (!I_RST) begin
            col_in_reg  <= '0;
            col_s1_reg  <= '0;
            pix_s1_reg  <= '0;
            de_s1_reg   <= 1'b0;
            sync_s1_reg <= '0;
        end else begin
            col_in_reg  <= I_DE ? col_in_reg + 1'b1 : '0;
            col_s1_reg  <= col_in_reg;
            pix_s1_reg  <= I_PIX_DATA;
            de_s1_reg   <= I_DE;
            sync_s1_reg <= {I_VSYNC, I_HSYNC, I_DE};
        end
    end

    // ---------------- sync delay: circular buffer + register chain ----------------
    logic [2:0]    sync_mem [H_TOTAL];
    logic [2:0]    sync_mem_q;
    logic [PW-1:0] sync_ptr_reg;
    logic          sync_primed_reg;
    logic          sync_valid_reg;
    logic [2:0]    sync_rd;
    logic [2:0]    sync_pre_reg;

    always_ff @(posedge I_PCLK) begin
        sync_mem[sync_ptr_reg] <= sync_s1_reg;
        sync_mem_q             <= sync_mem[sync_ptr_reg];
    end

    // Buffer RAM is not cleared; its output is masked until one full lap has been written.
    assign sync_rd = sync_valid_reg ? sync_mem_q : 3'b000;

    always_ff @(posedge I_PCLK or negedge I_RST) begin
        if (!I_RST) begin
            sync_ptr_reg    <= '0;
            sync_primed_reg <= 1'b0;
            sync_valid_reg  <= 1'b0;
            sync_pre_reg    <= '0;
        end else begin
            sync_ptr_reg   <= (sync_ptr_reg == PTR_LAST) ? '0 : sync_ptr_reg + 1'b1;
            if (sync_ptr_reg == PTR_LAST)
                sync_primed_reg <= 1'b1;
            sync_valid_reg <= sync_primed_reg;
            sync_pre_reg   <= sync_rd;
        end
    end

    // ---------------- stage 2: luminance + line buffers ----------------
    logic [15:0] y_sum;
    logic [7:0]  y_comb;

    assign y_sum  = 16'd77  * {8'd0, pix_s1_reg[23:16]}
                  + 16'd150 * {8'd0, pix_s1_reg[15:8]}
                  + 16'd29  * {8'd0, pix_s1_reg[7:0]};
    assign y_comb = 8'(y_sum >> 8);

    logic [7:0]    lb0_mem [H_ACT];
    logic [7:0]    lb1_mem [H_ACT];
    logic [7:0]    lb0_q;
    logic [7:0]    lb1_q;
    logic [7:0]    y_reg;
    logic          de_s2_reg;
    logic [AW-1:0] col_s2_reg;

    // Read-before-write: the row-above value leaves line 0 as the new Y lands, then drops into line 1.
    always_ff @(posedge I_PCLK) begin
        lb0_q <= lb0_mem[col_s1_reg];
        lb1_q <= lb1_mem[col_s1_reg];
        if (de_s1_reg)
            lb0_mem[col_s1_reg] <= y_comb;
        if (de_s2_reg)
            lb1_mem[col_s2_reg] <= lb0_q;
    end

    always_ff @(posedge I_PCLK or negedge I_RST) begin
        if (!I_RST) begin
            y_reg      <= '0;
            de_s2_reg  <= 1'b0;
            col_s2_reg <= '0;
        end else begin
            y_reg      <= y_comb;
            de_s2_reg  <= de_s1_reg;
            col_s2_reg <= col_s1_reg;
        end
    end

    // ---------------- stage 3: window ----------------
    // The newest column feeds the Sobel directly; registers hold the two older columns.
    logic [2:0][7:0] new_col;
    logic [2:0][7:0] win_c0;
    logic [2:0][7:0] win_c1;

    assign new_col = {y_reg, lb0_q, lb1_q};

    for (genvar gi = 0; gi < 3; gi++) begin : g_win
        logic [7:0] c0_reg;
        logic [7:0] c1_reg;

        always_ff @(posedge I_PCLK or negedge I_RST) begin
            if (!I_RST) begin
                c0_reg <= '0;
                c1_reg <= '0;
            end else if (de_s2_reg) begin
                c0_reg <= c1_reg;
                c1_reg <= new_col[gi];
            end
        end

        assign win_c0[gi] = c0_reg;
        assign win_c1[gi] = c1_reg;
    end

    function automatic logic [9:0] tap_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    logic [9:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx, gy;
    logic [10:0]       gx_abs, gy_abs;
    logic [11:0]       mag;
    logic [7:0]        m_sat;

    assign gx_pos = tap_sum(new_col[0], new_col[1], new_col[2]);
    assign gx_neg = tap_sum(win_c0[0],  win_c0[1],  win_c0[2]);
    assign gy_pos = tap_sum(win_c0[2],  win_c1[2],  new_col[2]);
    assign gy_neg = tap_sum(win_c0[0],  win_c1[0],  new_col[0]);
    assign gx     = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
    assign gy     = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    assign gx_abs = gx[10] ? $unsigned(-gx) : $unsigned(gx);
    assign gy_abs = gy[10] ? $unsigned(-gy) : $unsigned(gy);
    assign mag    = {1'b0, gx_abs} + {1'b0, gy_abs};
    assign m_sat  = (mag > 12'd255) ? 8'hFF : mag[7:0];

    // ---------------- stage 4: output position, border, output register ----------------
    // Position counters run on the delayed stream one cycle ahead of O_DE.
    logic          de_pre, vs_pre;
    logic [AW-1:0] out_col_reg;
    logic [RW-1:0] out_row_reg;
    logic          de_last_reg;
    logic          vs_last_reg;
    logic          vs_pol_reg;
    logic          vs_pol_known_reg;
    logic          vs_change, vs_clear, interior;

    assign de_pre    = sync_pre_reg[0];
    assign vs_pre    = sync_pre_reg[2];
    assign vs_change = (vs_pre != vs_last_reg);
    assign vs_clear  = vs_change && (!vs_pol_known_reg || (vs_pre == vs_pol_reg));
    assign interior  = (out_col_reg != '0) && (out_col_reg != COL_LAST) &&
                       (out_row_reg != '0) && (out_row_reg != ROW_LAST);

    always_ff @(posedge I_PCLK or negedge I_RST) begin
        if (!I_RST) begin
            out_col_reg      <= '0;
            out_row_reg      <= '0;
            de_last_reg      <= 1'b0;
            vs_last_reg      <= 1'b0;
            vs_pol_reg       <= 1'b0;
            vs_pol_known_reg <= 1'b0;
            O_PIX_DATA       <= '0;
            O_VSYNC          <= 1'b0;
            O_HSYNC          <= 1'b0;
            O_DE             <= 1'b0;
        end else begin
            out_col_reg <= de_pre ? out_col_reg + 1'b1 : '0;
            de_last_reg <= de_pre;
            vs_last_reg <= vs_pre;
            // The first VSYNC transition seen after reset fixes which edge restarts the row count.
            if (vs_change && !vs_pol_known_reg) begin
                vs_pol_known_reg <= 1'b1;
                vs_pol_reg       <= vs_pre;
            end
            if (vs_clear)
                out_row_reg <= '0;
            else if (de_last_reg && !de_pre)
                out_row_reg <= out_row_reg + 1'b1;
            O_PIX_DATA <= (de_pre && interior) ? {3{m_sat}} : '0;
            {O_VSYNC, O_HSYNC, O_DE} <= sync_pre_reg;
        end
    end

endmodule

// File: tb/tb_edge_detect_top.sv
// Bench for edge_detect_top on a reduced video raster: scoreboard of delayed sync and Sobel pixels.
module tb_edge_detect_top;
    localparam int H_ACT   = 64;
    localparam int V_ACT   = 16;
    localparam int H_TOTAL = 80;
    localparam int V_TOTAL = 20;
    localparam int H_FP    = 4;
    localparam int H_SYNC  = 6;
    localparam int V_FP    = 1;
    localparam int V_SYNC  = 1;
    localparam int LAT     = H_TOTAL + 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] pix_in = '0;
    logic        vs_in = 1'b1;
    logic        hs_in = 1'b1;
    logic        de_in = 1'b0;
    logic [23:0] pix_out;
    logic        vs_out, hs_out, de_out, pclk_out;

    edge_detect_top #(.H_ACT(H_ACT), .V_ACT(V_ACT), .H_TOTAL(H_TOTAL)) dut (
        .I_PCLK     (clk),
        .I_RST      (rst_n),
        .I_PIX_DATA (pix_in),
        .I_VSYNC    (vs_in),
        .I_HSYNC    (hs_in),
        .I_DE       (de_in),
        .O_PIX_DATA (pix_out),
        .O_VSYNC    (vs_out),
        .O_HSYNC    (hs_out),
        .O_DE       (de_out),
        .O_PCLK     (pclk_out)
    );

    always #5 clk = ~clk;

    int          n_vectors = 0;
    int          n_miscompares = 0;
    int          cyc = 0;
    int          in_rise_cyc = -1;
    int          out_rise_cyc = -1;
    logic [2:0]  sync_q [$];
    logic [31:0] pix_q [$];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [23:0] pattern(input int t, input int x, input int y);
        case (t)
            0:       return 24'h7F3A10;
            1:       return (x < H_ACT / 2) ? 24'h000000 : 24'hFFFFFF;
            2:       return (x < H_ACT / 2) ? 24'h000000 : 24'h101010;
            default: return (y < V_ACT / 2) ? 24'h000000 : 24'hFFFFFF;
        endcase
    endfunction

    function automatic int luma(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    function automatic logic [31:0] exp_pix(input int t, input int x, input int y);
        int p [3][3];
        int gx, gy, m;
        if (x == 0 || x == H_ACT - 1 || y == 0 || y == V_ACT - 1)
            return 32'd0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                p[r][c] = luma(pattern(t, x + c - 1, y + r - 1));
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255)
            m = 255;
        return 32'(m * 32'h010101);
    endfunction

    // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [23:0] pix, input logic vs, input logic hs, input logic de,
                        input bit score, input logic [31:0] expect_pix);
        logic [2:0] exp_sync;
        pix_in = pix;
        vs_in  = vs;
        hs_in  = hs;
        de_in  = de;
        if (score) begin
            sync_q.push_back({vs, hs, de});
            if (de)
                pix_q.push_back(expect_pix);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (score) begin
            if (de && in_rise_cyc < 0)
                in_rise_cyc = cyc;
            if (de_out && out_rise_cyc < 0)
                out_rise_cyc = cyc + 1;
            exp_sync = sync_q.pop_front();
            check_value("sync", {29'd0, vs_out, hs_out, de_out}, {29'd0, exp_sync});
            if (de_out) begin
                if (pix_q.size() == 0)
                    check_value("pix_underflow", 32'd0, 32'd1);
                else
                    check_value("pix", {8'd0, pix_out}, pix_q.pop_front());
            end else begin
                check_value("blank_pix", {8'd0, pix_out}, 32'd0);
            end
        end
        @(negedge clk);
    endtask

    task automatic run_frame(input int t, input int max_cycles, input bit score);
        int n = 0;
        for (int v = 0; v < V_TOTAL && n < max_cycles; v++) begin
            for (int h = 0; h < H_TOTAL && n < max_cycles; h++) begin
                logic de, hs, vs;
                de = (h < H_ACT) && (v < V_ACT);
                hs = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC));
                vs = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC));
                step(de ? pattern(t, h, v) : 24'($urandom), vs, hs, de, score,
                     de ? exp_pix(t, h, v) : 32'd0);
                n++;
            end
        end
    endtask

    int frame_test [5] = '{0, 1, 2, 3, 1};

    initial begin
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            pix_in = 24'($urandom);
            vs_in  = 1'($urandom);
            hs_in  = 1'($urandom);
            de_in  = 1'($urandom);
            @(posedge clk);
            #1;
            check_value("reset_out", {5'd0, pix_out, vs_out, hs_out, de_out}, 32'd0);
            @(negedge clk);
        end

        rst_n = 1'b1;
        for (int i = 0; i < LAT - 1; i++)
            sync_q.push_back(3'b000);

        foreach (frame_test[f])
            run_frame(frame_test[f], V_TOTAL * H_TOTAL, 1'b1);

        for (int i = 0; i < 2 * H_TOTAL; i++)
            step(24'($urandom), 1'b1, 1'b1, 1'b0, 1'b1, 32'd0);
        check_value("pix_drain", pix_q.size(), 32'd0);
        check_value("first_de_lat", 32'(out_rise_cyc - in_rise_cyc), 32'(LAT));

        // Mid-line reset: outputs must drop immediately while O_DE is active.
        run_frame(1, 2 * H_TOTAL + 30, 1'b0);
        check_value("pre_rst_de", {31'd0, de_out}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_out", {5'd0, pix_out, vs_out, hs_out, de_out}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/edge_detect_top.md
# edge_detect_top

Single-clock streaming Sobel edge detector that sits between the VGA video timing generator and the video output stage. It accepts 24-bit RGB pixels with VS/HS/DE timing, converts them to 8-bit luminance, and runs a 3x3 Sobel operator over a two-line buffer. It emits a greyscale edge-magnitude image with the input timing signals delayed to match the datapath latency.

## Interface
- H_ACT, 640: active pixels per line.
- V_ACT, 480: active lines per frame.
- H_TOTAL, 800: total pixel clocks per line, including blanking. Sets the sync delay.
- I_PCLK  in  1  pixel clock (25.175 MHz); all logic on rising edge.
- I_RST  in  1  reset, asynchronous, active-low.
- I_PIX_DATA  in  24  RGB pixel {R[23:16], G[15:8], B[7:0]}; valid when I_DE=1.
- I_VSYNC  in  1  vertical sync (polarity passed through unchanged).
- I_HSYNC  in  1  horizontal sync (polarity passed through unchanged).
- I_DE  in  1  data enable; high during active pixels.
- O_PIX_DATA  out  24  edge pixel {M, M, M}; 0 when O_DE=0.
- O_VSYNC  out  1  I_VSYNC delayed by LAT.
- O_HSYNC  out  1  I_HSYNC delayed by LAT.
- O_DE  out  1  I_DE delayed by LAT.
- O_PCLK  out  1  combinational copy of I_PCLK.

## Operation
- **Greyscale:** Y = (77·R + 150·G + 29·B) >> 8, computed in 16-bit unsigned. Examples: 0xFFFFFF→255, 0x101010→16.
- **Input column counter:**
  - Increments on each I_DE=1 cycle.
  - Clears when I_DE=0.
- **Line buffers:** two line buffers, each H_ACT×8 bits, indexed by the input column counter.
  - On each DE cycle, shift the current Y into line 0.
  - The old line-0 entry moves to line 1.
  - Buffers are written only when I_DE=1.
- **Window:** 3x3 window registers shift one column per DE cycle. Each new column is {line1 entry, line0 entry, new Y}, ordered top to bottom.
- **Sobel:**
  - Gx = (p[0][2] + 2p[1][2] + p[2][2]) − (p[0][0] + 2p[1][0] + p[2][0]).
  - Gy = (p[2][0] + 2p[2][1] + p[2][2]) − (p[0][0] + 2p[0][1] + p[0][2]).
  - Both are 11-bit signed.
  - M = min(|Gx| + |Gy|, 255).
- **Output centre:** the output pixel at output position (x, y) is the Sobel result centred on input pixel (x, y).
- **Output position tracking:**
  - Output column counter: increments on O_DE, clears when O_DE=0.
  - Output row counter: increments on each O_DE falling edge.
  - Row counter clears on the O_VSYNC active edge, i.e. the first change of O_VSYNC after reset, tracked as an edge.
- **Border:** rows 0 and V_ACT−1 and columns 0 and H_ACT−1 output M=0.
  - Consequence: interior outputs never depend on blanking-period data.
- **Outside DE:** O_PIX_DATA = 0 whenever O_DE=0.
- **Reset (I_RST=0):**
  - Outputs: O_PIX_DATA=0, O_DE=0, O_HSYNC=0, O_VSYNC=0.
  - Internal state: delay line, window registers, counters and pipeline registers all clear.
  - Line-buffer contents need not clear.
- **Reset mid-frame:** outputs go to 0 immediately. After release, O_DE stays 0 for LAT cycles, then tracks delayed I_DE. Output is correct from the next full frame.

## Timing
- LAT = H_TOTAL + 4 I_PCLK cycles, exactly (804 with defaults).
- O_DE, O_HSYNC and O_VSYNC equal their inputs delayed by exactly LAT cycles.
- Sync delay implementation: a 3-bit-wide circular buffer of depth H_TOTAL plus a 4-stage register chain.
- Datapath pipeline:
  - Stage 1: input register.
  - Stage 2: Y register.
  - Stage 3: window register.
  - Stage 4: M/output register.
- Alignment requirement: pixel (x, y) appears on O_PIX_DATA in the same cycle that the delayed O_DE marks output position (x, y).
- Continuous streaming at one pixel per clock; no backpressure and no stalls.
- The last output line (y = V_ACT−1) is emitted during the first vertical front-porch line. It is all zeros by the border rule.

## Test plan
- **Reset:** hold I_RST=0 with random inputs → all outputs 0. Release → O_DE first rises exactly 804 cycles after the first I_DE rise.
- **Flat frame:** full 640x480 frame of 0x7F3A10 → every captured output pixel = 0x000000.
- **Vertical edge:** columns 0–319 = 0x000000, columns 320–639 = 0xFFFFFF.
  - Rows 1–478, columns 319 and 320 → 0xFFFFFF (saturated).
  - All other pixels → 0.
- **Arithmetic:** same split as the vertical edge, but the right half is 0x101010.
  - Columns 319 and 320, interior rows → 0x404040 (Y=16, |Gx|=64).
  - All other pixels → 0.
- **Horizontal edge with border:** rows 0–239 black, rows 240–479 white.
  - Rows 239 and 240, columns 1–638 → 0xFFFFFF.
  - Columns 0 and 639 → 0.
  - Rows 0 and 479 → all 0.
- **Sync fidelity:** two consecutive VGA frames (800x525 total) → O_HSYNC, O_VSYNC and O_DE match the inputs shifted by exactly 804 cycles for the whole run. Second-frame output is identical to the first.
